// File: rtl/cla_pkg.sv
// Shared constants and the look-ahead carry function used at both the
// bit level (inside each group) and the group level (across groups).
package cla_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_GROUP = 4;

   // Widest g/p vector the look-ahead function handles. This limits both the
   // bits in one group and the number of groups.
   localparam int MAX_LANES = 16;

   // Carries c[0..MAX_LANES] from generate/propagate vectors and a carry-in.
   // Each c[k] is built as a flat sum of products:
   //   g[k-1] | p[k-1]g[k-2] | ... | p[k-1..0]cin
   // so there is no ripple dependency between the carries.
   function automatic logic [MAX_LANES:0] lookahead(
      input logic [MAX_LANES-1:0] g,
      input logic [MAX_LANES-1:0] p,
      input logic                 cin
   );
      logic [MAX_LANES:0] c;
      logic               term;
      c    = '0;
      c[0] = cin;
      for (int k = 1; k <= MAX_LANES; k++) begin
         c[k] = g[k-1];
         term = p[k-1];
         for (int j = k - 2; j >= 0; j--) begin
            c[k] = c[k] | (term & g[j]);
            term = term & p[j];
         end
         c[k] = c[k] | (term & cin);
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-look-ahead leaf. This block is purely combinational and
// exports its group generate/propagate signals to the second look-ahead level.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = DEFAULT_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             group_g,
   output logic             group_p
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Only the carries into each bit are needed here. The carry out of the
   // group comes from the upper level instead.
   assign c   = GROUP'(lookahead(MAX_LANES'(g), MAX_LANES'(p), cin));
   assign sum = p ^ c;

   // Group generate is the group carry-out with a zero carry-in.
   assign group_g = 1'(lookahead(MAX_LANES'(g), MAX_LANES'(p), 1'b0) >> GROUP);
   assign group_p = &p;

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered two-level carry-look-ahead adder: {Cout,Sum} = A + B + Cin,
// one result per clock with a fixed one-cycle latency.
module carry_look_ahead_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int GROUP = DEFAULT_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             out_valid
);

   localparam int NGROUPS = WIDTH / GROUP;

   if (WIDTH < 1 || GROUP < 1 || (WIDTH % GROUP) != 0 ||
       GROUP > MAX_LANES || NGROUPS > MAX_LANES) begin : g_bad_cfg
      $error("carry_look_ahead_adder: unsupported WIDTH/GROUP combination");
   end

   logic [NGROUPS-1:0] grp_g;
   logic [NGROUPS-1:0] grp_p;
   logic [NGROUPS:0]   grp_c;
   logic [WIDTH-1:0]   sum_next;

   // Second look-ahead level: the carry into each group comes straight from
   // the group G/P values and Cin, so no carry passes through a group.
   assign grp_c = (NGROUPS + 1)'(lookahead(MAX_LANES'(grp_g), MAX_LANES'(grp_p), Cin));

   for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
      cla_group #(
         .GROUP (GROUP)
      ) u_grp (
         .a       (A[gi*GROUP +: GROUP]),
         .b       (B[gi*GROUP +: GROUP]),
         .cin     (grp_c[gi]),
         .sum     (sum_next[gi*GROUP +: GROUP]),
         .group_g (grp_g[gi]),
         .group_p (grp_p[gi])
      );
   end

   // NOTE: state uses non-blocking assignments, and "hold" is an enable on
   // the flops rather than a missing else in combinational logic. The
   // enable therefore cannot infer a latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum       <= '0;
         Cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Sum  <= sum_next;
            Cout <= grp_c[NGROUPS];
         end
      end
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Scoreboard bench: a 4-bit default instance driven from directed vectors and
// an 8-bit, two-group instance swept against A+B+Cin.
module tb_carry_look_ahead_adder;

   typedef struct {
      logic       valid;
      logic [7:0] sum;
      logic       cout;
   } exp_t;

   logic clk;
   logic rst_n;

   logic       valid4, cin4, cout4, ovalid4;
   logic [3:0] a4, b4, sum4;
   logic       valid8, cin8, cout8, ovalid8;
   logic [7:0] a8, b8, sum8;

   exp_t q4[$];
   exp_t q8[$];
   logic [3:0] hold4_sum;
   logic       hold4_cout;
   logic [7:0] hold8_sum;
   logic       hold8_cout;

   int n_checks;
   int n_fail;

   carry_look_ahead_adder u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid4),
      .A         (a4),
      .B         (b4),
      .Cin       (cin4),
      .Sum       (sum4),
      .Cout      (cout4),
      .out_valid (ovalid4)
   );

   carry_look_ahead_adder #(
      .WIDTH (8),
      .GROUP (4)
   ) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid8),
      .A         (a8),
      .B         (b8),
      .Cin       (cin8),
      .Sum       (sum8),
      .Cout      (cout8),
      .out_valid (ovalid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // 4-bit instance: expected values are supplied by the caller.
   task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic [3:0] es, input logic ec);
      exp_t e;
      @(negedge clk);
      valid4 = v;
      a4     = a;
      b4     = b;
      cin4   = ci;
      if (v) begin
         hold4_sum  = es;
         hold4_cout = ec;
      end
      e.valid = v;
      e.sum   = {4'b0, hold4_sum};
      e.cout  = hold4_cout;
      q4.push_back(e);
   endtask

   // 8-bit instance: expected values come from a 9-bit reference sum.
   task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
      exp_t       e;
      logic [8:0] full;
      @(negedge clk);
      valid8 = v;
      a8     = a;
      b8     = b;
      cin8   = ci;
      if (v) begin
         full       = 9'(a) + 9'(b) + 9'(ci);
         hold8_sum  = full[7:0];
         hold8_cout = full[8];
      end
      e.valid = v;
      e.sum   = hold8_sum;
      e.cout  = hold8_cout;
      q8.push_back(e);
   endtask

   // Outputs are sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (q4.size() > 0) begin
            e = q4.pop_front();
            check("d4_out_valid", 32'(ovalid4), 32'(e.valid));
            check("d4_sum",       32'(sum4),    32'(e.sum));
            check("d4_cout",      32'(cout4),   32'(e.cout));
         end else begin
            check("d4_idle_valid", 32'(ovalid4), 32'd0);
         end
         if (q8.size() > 0) begin
            e = q8.pop_front();
            check("d8_out_valid", 32'(ovalid8), 32'(e.valid));
            check("d8_sum",       32'(sum8),    32'(e.sum));
            check("d8_cout",      32'(cout8),   32'(e.cout));
         end else begin
            check("d8_idle_valid", 32'(ovalid8), 32'd0);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      {valid4, a4, b4, cin4} = '0;
      {valid8, a8, b8, cin8} = '0;
      hold4_sum  = '0;
      hold4_cout = 1'b0;
      hold8_sum  = '0;
      hold8_cout = 1'b0;

      // Reset state while the clock is running.
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum4",    32'(sum4),    32'd0);
      check("rst_cout4",   32'(cout4),   32'd0);
      check("rst_valid4",  32'(ovalid4), 32'd0);
      check("rst_sum8",    32'(sum8),    32'd0);
      check("rst_cout8",   32'(cout8),   32'd0);
      check("rst_valid8",  32'(ovalid8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed 4-bit vectors, driven back to back.
      drive4(1'b1, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0);
      drive4(1'b1, 4'b1000, 4'b1101, 1'b1, 4'b0110, 1'b1);
      drive4(1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1);
      drive4(1'b1, 4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1);
      drive4(1'b1, 4'b1101, 4'b0111, 1'b0, 4'b0100, 1'b1);
      drive4(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
      drive4(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      drive4(1'b1, 4'b1001, 4'b0011, 1'b0, 4'b1100, 1'b0);

      // With in_valid low, the previous result is held while the inputs change.
      drive4(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0);
      drive4(1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0);
      drive4(1'b1, 4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1);

      // Reset pulsed between edges clears the live result immediately.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_sum4",   32'(sum4),    32'd0);
      check("midrst_cout4",  32'(cout4),   32'd0);
      check("midrst_valid4", 32'(ovalid4), 32'd0);
      q4.delete();
      q8.delete();
      hold4_sum  = '0;
      hold4_cout = 1'b0;
      hold8_sum  = '0;
      hold8_cout = 1'b0;
      #1;
      rst_n = 1'b1;
      drive4(1'b0, 4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b0);
      drive4(1'b1, 4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0);
      drive4(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // 8-bit, two-group instance: boundary vectors, a strided sweep, then random vectors.
      drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
      drive8(1'b1, 8'h00, 8'h00, 1'b0);
      drive8(1'b1, 8'hFF, 8'h01, 1'b0);
      drive8(1'b1, 8'h0F, 8'h00, 1'b1);
      drive8(1'b0, 8'h12, 8'h34, 1'b0);
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b += 5) begin
            for (int c = 0; c < 2; c++) begin
               drive8(1'b1, 8'(a), 8'(b), 1'(c));
            end
         end
      end
      for (int i = 0; i < 500; i++) begin
         drive8(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      end
      drive8(1'b0, 8'h00, 8'h00, 1'b0);

      // Bounded drain of the outstanding expectations.
      for (int i = 0; i < 8 && (q4.size() > 0 || q8.size() > 0); i++) begin
         @(posedge clk);
         #2;
      end
      check("drain_queues", 32'(q4.size() + q8.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
